// File: rtl/reset_seq_pkg.sv
// Shared FSM state encoding and reset-cause codes for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    RUN      = 2'd1,
    BTN_HELD = 2'd2,
    STRETCH  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_EXT = 2'b10;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus consecutive-cycle debouncer for the raw reset button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_raw,
  output logic btn_n_clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1     <= 1'b1;
      sync_q2     <= 1'b1;
      cnt         <= '0;
      btn_n_clean <= 1'b1;
    end else begin
      sync_q1 <= btn_n_raw;
      sync_q2 <= sync_q1;
      // any cycle that agrees with the accepted level restarts the run
      if (sync_q2 == btn_n_clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt         <= '0;
        btn_n_clean <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset sequencer: power-on hold, debounced button, request-driven stretch,
// with reset release aligned to the clk_en pulse.
//   state    | meaning
//   POR_HOLD | after block reset, count HOLD_CYCLES then release on clk_en
//   RUN      | SoC out of reset, ready high
//   BTN_HELD | debounced button pressed, SoC held in reset
//   STRETCH  | minimum hold after button release or external request
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = 20,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CLK_DIV         = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_btn_n,
  input  logic       ext_reset_req,
  output logic       soc_reset,
  output logic       clk_en,
  output logic       ready,
  output logic [1:0] reset_cause
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [1:0]        cause_nxt;
  logic [7:0]        div_cnt;
  logic [7:0]        div_nxt;
  logic              en_nxt;
  logic              hold_done;
  logic              btn_n_clean;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .btn_n_raw  (rst_btn_n),
    .btn_n_clean(btn_n_clean)
  );

  assign div_nxt = (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
  assign en_nxt  = (div_nxt == DIV_LAST);

  // Look at next cycle's clk_en so the first RUN cycle is itself a clk_en cycle.
  assign hold_done = (hold_cnt == HOLD_MAX) && en_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= 8'd0;
      clk_en  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      clk_en  <= en_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= POR_HOLD;
      hold_cnt    <= '0;
      reset_cause <= CAUSE_POR;
      soc_reset   <= 1'b1;
      ready       <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      reset_cause <= cause_nxt;
      soc_reset   <= (state_nxt != RUN);
      ready       <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = reset_cause;
    hold_nxt  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    case (state)
      POR_HOLD: begin
        if (hold_done) state_nxt = RUN;
      end
      RUN: begin
        if (!btn_n_clean) begin
          state_nxt = BTN_HELD;
          cause_nxt = CAUSE_BTN;
          hold_nxt  = '0;
        end else if (ext_reset_req) begin
          state_nxt = STRETCH;
          cause_nxt = CAUSE_EXT;
          hold_nxt  = '0;
        end
      end
      BTN_HELD: begin
        hold_nxt = '0;
        if (btn_n_clean) state_nxt = STRETCH;
      end
      STRETCH: begin
        if (!btn_n_clean) begin
          state_nxt = BTN_HELD;
          cause_nxt = CAUSE_BTN;
          hold_nxt  = '0;
        end else if (hold_done) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = POR_HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

endmodule
